// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA screen geometry, colour codes and arbiter state type
package vga_pkg;

    localparam int VGA_X_SZ   = 8;
    localparam int VGA_Y_SZ   = 7;
    localparam int VGA_COL_SZ = 3;
    localparam int VGA_X_MAX  = 160;
    localparam int VGA_Y_MAX  = 120;

    typedef enum logic [2:0] {
        COL_BLACK   = 3'd0,
        COL_BLUE    = 3'd1,
        COL_GREEN   = 3'd2,
        COL_CYAN    = 3'd3,
        COL_RED     = 3'd4,
        COL_MAGENTA = 3'd5,
        COL_YELLOW  = 3'd6,
        COL_WHITE   = 3'd7
    } colour_e;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_OWN = 1'b1
    } arb_state_e;

    function automatic logic on_screen(input int x, input int y, input int x_lim, input int y_lim);
        return (x < x_lim) && (y < y_lim);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector searching upward from last_owner+1
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_owner_i,
    output logic [N_REQ-1:0] winner_o,
    output logic [IW-1:0]    winner_idx_o
);

    // Walk from farthest to nearest so the nearest active requester overwrites the rest.
    always_comb begin
        int j;
        winner_o     = '0;
        winner_idx_o = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(last_owner_i) + k) % N_REQ;
            if (req_i[j]) begin
                winner_o     = '0;
                winner_o[j]  = 1'b1;
                winner_idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter sharing the vga_adapter pixel port with lock and burst limit
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int xSz       = VGA_X_SZ,
    parameter int ySz       = VGA_Y_SZ,
    parameter int colSz     = VGA_COL_SZ,
    parameter int X_MAX     = VGA_X_MAX,
    parameter int Y_MAX     = VGA_Y_MAX,
    parameter int MAX_BURST = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*xSz-1:0]   x_in,
    input  logic [N_REQ*ySz-1:0]   y_in,
    input  logic [N_REQ*colSz-1:0] col_in,
    output logic [N_REQ-1:0]       grant,
    output logic [xSz-1:0]         x_for_vga,
    output logic [ySz-1:0]         y_for_vga,
    output logic [colSz-1:0]       col_for_vga,
    output logic                   plotEn,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [xSz-1:0]   x_q, x_d;
    logic [ySz-1:0]   y_q, y_d;
    logic [colSz-1:0] col_q, col_d;
    logic             plot_q, plot_d;

    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic [xSz-1:0]   own_x;
    logic [ySz-1:0]   own_y;
    logic [colSz-1:0] own_col;
    logic             accept;
    logic             others_waiting;
    logic             burst_full;
    logic             burst_hit;
    logic             release_own;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (owner_q),
        .winner_o     (pick_onehot),
        .winner_idx_o (pick_idx)
    );

    assign own_x   = x_in[int'(owner_q)*xSz +: xSz];
    assign own_y   = y_in[int'(owner_q)*ySz +: ySz];
    assign own_col = col_in[int'(owner_q)*colSz +: colSz];

    assign accept         = (state_q == ST_OWN) && req[owner_q] && grant_q[owner_q];
    assign others_waiting = |(req & ~grant_q);
    assign burst_full     = (int'(burst_q) == MAX_BURST);
    // Count the pixel taken this cycle so the limit yields exactly MAX_BURST plots.
    assign burst_hit      = burst_full || (accept && (int'(burst_q) == MAX_BURST - 1));
    assign release_own    = !lock[owner_q] && (!req[owner_q] || (burst_hit && others_waiting));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            grant_q <= '0;
            owner_q <= IW'(N_REQ - 1);
            burst_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        burst_d = burst_q;
        if (state_q == ST_ARB) begin
            if (|req) begin
                state_d = ST_OWN;
                grant_d = pick_onehot;
                owner_d = pick_idx;
                burst_d = '0;
            end else begin
                grant_d = '0;
            end
        end else begin
            if (accept && !burst_full) begin
                burst_d = burst_q + BW'(1);
            end
            if (release_own) begin
                state_d = ST_ARB;
                grant_d = '0;
            end
        end
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        col_d  = col_q;
        plot_d = 1'b0;
        if (accept) begin
            x_d    = own_x;
            y_d    = own_y;
            col_d  = own_col;
            plot_d = on_screen(int'(own_x), int'(own_y), X_MAX, Y_MAX);
        end
    end

    assign grant       = grant_q;
    assign busy        = |grant_q;
    assign x_for_vga   = x_q;
    assign y_for_vga   = y_q;
    assign col_for_vga = col_q;
    assign plotEn      = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed table-driven bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [2:0]  c0, c1;
    logic [1:0]  grant;
    logic [7:0]  x_for_vga;
    logic [6:0]  y_for_vga;
    logic [2:0]  col_for_vga;
    logic        plotEn;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vga_plot_arbiter #(
        .N_REQ     (2),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .x_in        ({x1, x0}),
        .y_in        ({y1, y0}),
        .col_in      ({c1, c0}),
        .grant       (grant),
        .x_for_vga   (x_for_vga),
        .y_for_vga   (y_for_vga),
        .col_for_vga (col_for_vga),
        .plotEn      (plotEn),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] x0;
        logic [6:0] y0;
        logic [2:0] c0;
        logic [1:0] g;
        logic       p;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [1:0] r, input int xa, input int ya, input int ca,
                                input logic [1:0] g, input logic p, input int ex, input int ey, input int ec);
        vec_t v;
        v.req = r;
        v.x0  = 8'(xa);
        v.y0  = 7'(ya);
        v.c0  = 3'(ca);
        v.g   = g;
        v.p   = p;
        v.ex  = 8'(ex);
        v.ey  = 7'(ey);
        v.ec  = 3'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        lock  = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        lock  = 2'b00;
        x0 = 8'd0;  y0 = 7'd0;  c0 = 3'd0;
        x1 = 8'd50; y1 = 7'd60; c1 = 3'd2;

        step();
        step();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_plot", 32'(plotEn), 32'd0);
        chk("reset_x", 32'(x_for_vga), 32'd0);
        chk("reset_y", 32'(y_for_vga), 32'd0);
        chk("reset_col", 32'(col_for_vga), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // single requester, then bounds, then round-robin alternation
        vecs[0]  = mk(2'b01,  10,  20, 3, 2'b01, 1'b0,   0,   0, 0);
        vecs[1]  = mk(2'b01,  10,  20, 3, 2'b01, 1'b1,  10,  20, 3);
        vecs[2]  = mk(2'b01,  11,  20, 3, 2'b01, 1'b1,  11,  20, 3);
        vecs[3]  = mk(2'b01,  12,  20, 3, 2'b01, 1'b1,  12,  20, 3);
        vecs[4]  = mk(2'b00,  12,  20, 3, 2'b00, 1'b0,  12,  20, 3);
        vecs[5]  = mk(2'b00,   0,   0, 0, 2'b00, 1'b0,  12,  20, 3);
        vecs[6]  = mk(2'b01, 159, 119, 5, 2'b01, 1'b0,  12,  20, 3);
        vecs[7]  = mk(2'b01, 159, 119, 5, 2'b01, 1'b1, 159, 119, 5);
        vecs[8]  = mk(2'b01, 160,   5, 6, 2'b01, 1'b0, 160,   5, 6);
        vecs[9]  = mk(2'b01,   5, 120, 7, 2'b01, 1'b0,   5, 120, 7);
        vecs[10] = mk(2'b00,   5, 120, 7, 2'b00, 1'b0,   5, 120, 7);
        vecs[11] = mk(2'b11,  30,  40, 1, 2'b10, 1'b0,   5, 120, 7);
        vecs[12] = mk(2'b11,  30,  40, 1, 2'b10, 1'b1,  50,  60, 2);
        vecs[13] = mk(2'b01,  30,  40, 1, 2'b00, 1'b0,  50,  60, 2);
        vecs[14] = mk(2'b11,  30,  40, 1, 2'b01, 1'b0,  50,  60, 2);
        vecs[15] = mk(2'b11,  30,  40, 1, 2'b01, 1'b1,  30,  40, 1);
        vecs[16] = mk(2'b10,  30,  40, 1, 2'b00, 1'b0,  30,  40, 1);
        vecs[17] = mk(2'b11,  30,  40, 1, 2'b10, 1'b0,  30,  40, 1);
        vecs[18] = mk(2'b10,  30,  40, 1, 2'b10, 1'b1,  50,  60, 2);
        vecs[19] = mk(2'b01,  30,  40, 1, 2'b00, 1'b0,  50,  60, 2);

        for (int i = 0; i < 20; i++) begin
            req = vecs[i].req;
            x0  = vecs[i].x0;
            y0  = vecs[i].y0;
            c0  = vecs[i].c0;
            step();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].g != 2'b00));
            chk($sformatf("vec%0d_plot", i), 32'(plotEn), 32'(vecs[i].p));
            chk($sformatf("vec%0d_x", i), 32'(x_for_vga), 32'(vecs[i].ex));
            chk($sformatf("vec%0d_y", i), 32'(y_for_vga), 32'(vecs[i].ey));
            chk($sformatf("vec%0d_col", i), 32'(col_for_vga), 32'(vecs[i].ec));
        end

        // burst limit of 4 with both requesting
        do_reset();
        x0 = 8'd20; y0 = 7'd30; c0 = 3'd4;
        req = 2'b11;
        begin
            logic [1:0] bg [7];
            logic       bp [7];
            bg = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
            bp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 7; i++) begin
                step();
                chk($sformatf("burst%0d_grant", i), 32'(grant), 32'(bg[i]));
                chk($sformatf("burst%0d_plot", i), 32'(plotEn), 32'(bp[i]));
            end
        end
        req = 2'b01;
        step();
        chk("burst_rel1_grant", 32'(grant), 32'd0);
        step();
        chk("burst_solo_grant", 32'(grant), 32'b01);
        chk("burst_solo_plot", 32'(plotEn), 32'd0);
        for (int i = 0; i < 8; i++) begin
            x0 = 8'(40 + i);
            step();
            chk($sformatf("solo%0d_grant", i), 32'(grant), 32'b01);
            chk($sformatf("solo%0d_plot", i), 32'(plotEn), 32'd1);
            chk($sformatf("solo%0d_x", i), 32'(x_for_vga), 32'(40 + i));
        end

        // lock holds requester 0 while requester 1 waits
        do_reset();
        x0 = 8'd7; y0 = 7'd8; c0 = 3'd1;
        lock = 2'b01;
        req  = 2'b11;
        step();
        chk("lock_first_grant", 32'(grant), 32'b01);
        for (int i = 0; i < 100; i++) begin
            req = {1'b1, (i % 2) == 1};
            step();
            chk($sformatf("lock%0d_grant", i), 32'(grant), 32'b01);
            chk($sformatf("lock%0d_plot", i), 32'(plotEn), 32'((i % 2) == 1));
        end
        lock = 2'b00;
        req  = 2'b10;
        step();
        chk("unlock_grant_drop", 32'(grant), 32'd0);
        step();
        chk("unlock_grant1", 32'(grant), 32'b10);

        // asynchronous reset during an owned burst
        do_reset();
        x0 = 8'd90; y0 = 7'd70; c0 = 3'd6;
        req = 2'b01;
        step();
        step();
        step();
        chk("pre_rst_plot", 32'(plotEn), 32'd1);
        chk("pre_rst_x", 32'(x_for_vga), 32'd90);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_plot", 32'(plotEn), 32'd0);
        chk("async_rst_x", 32'(x_for_vga), 32'd0);
        chk("async_rst_y", 32'(y_for_vga), 32'd0);
        chk("async_rst_col", 32'(col_for_vga), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b0;
        req   = 2'b11;
        step();
        chk("post_rst_grant", 32'(grant), 32'b01);
        chk("post_rst_plot", 32'(plotEn), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between several pixel producers, for example the box drawer and a background-erase engine.
- Arbitrates round-robin, honours atomic lock bursts so a whole box is drawn without interleaving, and bounds unlocked bursts to prevent starvation.
- Registers the winning pixel onto the adapter inputs.
- Sits between the star-finder drawing engines and vga_adapter, replacing the direct draw_box connection.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- xSz, 8, x coordinate width.
- ySz, 7, y coordinate width.
- colSz, 3, colour width.
- X_MAX, 160, screen width; pixels with x >= X_MAX are dropped.
- Y_MAX, 120, screen height; pixels with y >= Y_MAX are dropped.
- MAX_BURST, 64, maximum accepted pixels per unlocked grant while others wait.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester pixel-valid / request.
- lock  in  N_REQ  per-requester hold-grant (atomic burst).
- x_in  in  N_REQ*xSz  flattened x; requester i occupies bits [i*xSz +: xSz].
- y_in  in  N_REQ*ySz  flattened y, same packing.
- col_in  in  N_REQ*colSz  flattened colour, same packing.
- grant  out  N_REQ  one-hot (or zero) owner indication, registered.
- x_for_vga  out  xSz  registered pixel x.
- y_for_vga  out  ySz  registered pixel y.
- col_for_vga  out  colSz  registered pixel colour.
- plotEn  out  1  registered write strobe to vga_adapter.
- busy  out  1  high whenever grant != 0.

Behaviour:
- Reset (asynchronous, immediate, including mid-burst):
  - grant = 0, plotEn = 0, x/y/col_for_vga = 0, busy = 0.
  - burst counter = 0, last_owner = N_REQ-1 (so requester 0 wins first), state = ARB.
- State ARB:
  - If req == 0, stay in ARB with grant = 0.
  - Otherwise select the first i with req[i] = 1, searching from last_owner+1 upward and wrapping modulo N_REQ.
  - Next cycle: grant = onehot(i), last_owner = i, burst = 0, state = OWN.
  - No pixel is accepted in ARB; this is the one-cycle arbitration bubble.
- State OWN (owner o):
  - A pixel is accepted on every cycle where req[o] && grant[o].
  - On acceptance: x/y/col_for_vga <= requester o's fields and burst increments, saturating at MAX_BURST.
  - plotEn <= 1 only if x < X_MAX and y < Y_MAX. Out-of-range pixels are still accepted and consumed, but plotEn stays 0.
  - Latency from acceptance to plotEn is exactly 1 cycle. plotEn = 0 on every cycle without acceptance.
  - Colour is passed through unmodified.
- Release from OWN: grant drops next cycle and state returns to ARB when either condition holds:
  - a) req[o] = 0 and lock[o] = 0;
  - b) lock[o] = 0 and burst has reached MAX_BURST and (req & ~onehot(o)) != 0.
- If lock[o] = 1, the owner keeps the grant regardless of req[o] or burst (idle cycles inside a lock produce no plot).
- If req[o] = 1 and the burst limit is reached but no other requester is active, ownership continues and burst stays saturated.
- Simultaneous requests are resolved only by the round-robin pointer. Requests arriving while another requester owns the port wait; there is no pre-emption.
- A requester must hold its fields stable while req is high and grant is low. Fields are sampled only on acceptance cycles.
- The cycle after release is always ARB, so back-to-back owners are separated by exactly one bubble cycle. The same requester may win again if it is the only one requesting.

Decomposition:
- Shared package (vga_pkg): X_MAX, Y_MAX, xSz, ySz, colSz constants and the colour codes already used by draw_box.
- One natural sub-module, rr_pick: combinational round-robin priority selector. Inputs are req and last_owner; outputs are the one-hot winner and its index.
- The FSM, burst counter, bounds check and output registers live in vga_plot_arbiter.

Test Plan:
- Single requester:
  - Stimulus: after reset, req[0] = 1 for 3 cycles with pixels (10,20,3), (11,20,3), (12,20,3), then req[0] = 0.
  - Required: grant[0] rises 1 cycle after req; plotEn is high for exactly 3 cycles with those values, each 1 cycle after acceptance; grant drops 1 cycle after req falls.
- Round-robin:
  - Stimulus: req = 2'b11 continuously, each burst terminated by dropping req for 1 cycle.
  - Required: grant order 01, 10, 01, 10, with a 1-cycle grant = 0 bubble between owners.
- Burst limit:
  - Stimulus: MAX_BURST = 4, req[0] and req[1] held high, lock = 0.
  - Required: requester 0 plots 4 pixels, grant moves to requester 1 after the bubble; with only req[0] high, requester 0 keeps plotting beyond 4.
- Lock:
  - Stimulus: lock[0] = 1 while req[0] toggles and req[1] is held high for 100 cycles.
  - Required: grant[1] never asserts until lock[0] falls; plotEn only on cycles where req[0] is high.
- Bounds:
  - Stimulus: pixels (159,119), (160,5), (5,120).
  - Required: plotEn = 1 for the first pixel only; all three pixels are accepted (grant is held and burst = 3).
- Reset mid-burst:
  - Stimulus: assert reset asynchronously during an OWN burst.
  - Required: grant, plotEn and outputs go to 0 immediately without waiting for a clock edge; after release, requester 0 wins first when req = 2'b11.
